arith_arbiter: RTL and testbench

ARITH_ARBITER -- requirements
Module: arith_arbiter

---
 rtl/arith_arbiter.sv | 64 ++++++
 tb/tb_arith_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/arith_arbiter.sv
// arith_arbiter: two-requester arbiter sharing one registered add/subtract datapath
// Ports: clk, reset (sync, active-high)
//   reqK_valid/reqK_ready        request handshake for requester K (0/1)
//   reqK_operandA/B, reqK_control operands; control 0 = add, 1 = subtract
//   rsp_valid/rsp_ready          response handshake
//   rsp_id, rsp_result, rsp_carryOut, rsp_zero  registered response fields
module arith_arbiter #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [SIZE-1:0] req0_operandA,
  input  logic [SIZE-1:0] req0_operandB,
  input  logic            req0_control,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [SIZE-1:0] req1_operandA,
  input  logic [SIZE-1:0] req1_operandB,
  input  logic            req1_control,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [SIZE-1:0] rsp_result,
  output logic            rsp_carryOut,
  output logic            rsp_zero
);
  logic prio, slotFree, grant0, grant1, accept, sel, ctl;
  logic [SIZE-1:0] opA, opB;
  logic [SIZE:0] sum;
  always_comb begin
    slotFree = ~rsp_valid | rsp_ready;
    grant0 = req0_valid & (~req1_valid | ~prio);
    grant1 = req1_valid & (~req0_valid | prio);
    req0_ready = grant0 & slotFree & ~reset;
    req1_ready = grant1 & slotFree & ~reset;
    accept = req0_ready | req1_ready;
    sel = req1_ready;
    opA = sel ? req1_operandA : req0_operandA;
    opB = sel ? req1_operandB : req0_operandB;
    ctl = sel ? req1_control : req0_control;
    sum = {1'b0, opA} + {1'b0, ctl ? ~opB : opB} + {{SIZE{1'b0}}, ctl};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_result <= '0;
      rsp_carryOut <= 1'b0;
      rsp_zero <= 1'b0;
      prio <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id <= sel;
      rsp_result <= sum[SIZE-1:0];
      rsp_carryOut <= sum[SIZE];
      rsp_zero <= ~|sum[SIZE-1:0];
      prio <= ~sel;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_arith_arbiter.sv
// tb_arith_arbiter: directed self-checking bench for arith_arbiter
module tb_arith_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, req0_control = 1'b0, req1_control = 1'b0;
  logic [31:0] req0_operandA = '0, req0_operandB = '0, req1_operandA = '0, req1_operandB = '0;
  logic rsp_ready = 1'b0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_carryOut, rsp_zero;
  logic [31:0] rsp_result;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  arith_arbiter #(.SIZE(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_operandA(req0_operandA),
    .req0_operandB(req0_operandB), .req0_control(req0_control),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_operandA(req1_operandA),
    .req1_operandB(req1_operandB), .req1_control(req1_control),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carryOut(rsp_carryOut), .rsp_zero(rsp_zero)
  );

  task automatic setReq0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic c);
    req0_valid = v; req0_operandA = a; req0_operandB = b; req0_control = c;
  endtask

  task automatic setReq1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic c);
    req1_valid = v; req1_operandA = a; req1_operandB = b; req1_control = c;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1; rsp_ready = 1'b1;
    setReq0(1'b1, 32'd1, 32'd1, 1'b0);
    setReq1(1'b1, 32'd2, 32'd2, 1'b0);
    #1;
    tests++; if ({req0_ready, req1_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready got %b exp 00", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    tests++; if ({rsp_valid, rsp_id, rsp_carryOut, rsp_zero} !== 4'b0000) begin fails++; $display("FAIL reset_flags got %b exp 0000", {rsp_valid, rsp_id, rsp_carryOut, rsp_zero}); end
    tests++; if (rsp_result !== 32'd0) begin fails++; $display("FAIL reset_result got %0h exp 0", rsp_result); end
  endtask

  task automatic test_add;
    @(negedge clk);
    reset = 1'b0; rsp_ready = 1'b1;
    setReq0(1'b1, 32'd5, 32'd3, 1'b0);
    setReq1(1'b0, 32'd9, 32'd9, 1'b1);
    #1;
    tests++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL add_ready got %b exp 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    setReq0(1'b0, 32'd0, 32'd0, 1'b0);
    tests++; if ({rsp_valid, rsp_id, rsp_carryOut, rsp_zero} !== 4'b1000) begin fails++; $display("FAIL add_flags got %b exp 1000", {rsp_valid, rsp_id, rsp_carryOut, rsp_zero}); end
    tests++; if (rsp_result !== 32'd8) begin fails++; $display("FAIL add_result got %0h exp 8", rsp_result); end
    @(posedge clk); #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL add_drain got %b exp 0", rsp_valid); end
  endtask

  task automatic test_sub;
    @(negedge clk);
    setReq1(1'b1, 32'd3, 32'd3, 1'b1);
    @(posedge clk); #1;
    setReq1(1'b1, 32'd0, 32'd1, 1'b1);
    tests++; if ({rsp_valid, rsp_id, rsp_carryOut, rsp_zero} !== 4'b1111) begin fails++; $display("FAIL sub_eq_flags got %b exp 1111", {rsp_valid, rsp_id, rsp_carryOut, rsp_zero}); end
    tests++; if (rsp_result !== 32'd0) begin fails++; $display("FAIL sub_eq_result got %0h exp 0", rsp_result); end
    @(posedge clk); #1;
    setReq1(1'b0, 32'd0, 32'd0, 1'b0);
    tests++; if ({rsp_valid, rsp_id, rsp_carryOut, rsp_zero} !== 4'b1100) begin fails++; $display("FAIL sub_borrow_flags got %b exp 1100", {rsp_valid, rsp_id, rsp_carryOut, rsp_zero}); end
    tests++; if (rsp_result !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sub_borrow_result got %0h exp ffffffff", rsp_result); end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    setReq0(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    @(posedge clk); #1;
    setReq0(1'b0, 32'd0, 32'd0, 1'b0);
    tests++; if ({rsp_valid, rsp_id, rsp_carryOut, rsp_zero} !== 4'b1011) begin fails++; $display("FAIL wrap_flags got %b exp 1011", {rsp_valid, rsp_id, rsp_carryOut, rsp_zero}); end
    tests++; if (rsp_result !== 32'd0) begin fails++; $display("FAIL wrap_result got %0h exp 0", rsp_result); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] expRes [2];
    logic expCarry [2];
    expRes[0] = 32'd11; expCarry[0] = 1'b0;
    expRes[1] = 32'd18; expCarry[1] = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; rsp_ready = 1'b1;
    setReq0(1'b1, 32'd10, 32'd1, 1'b0);
    setReq1(1'b1, 32'd20, 32'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++; if ({req0_ready, req1_ready} !== ((i % 2) ? 2'b01 : 2'b10)) begin fails++; $display("FAIL alt_grant[%0d] got %b exp %b", i, {req0_ready, req1_ready}, (i % 2) ? 2'b01 : 2'b10); end
      @(posedge clk); #1;
      tests++; if ({rsp_valid, rsp_id, rsp_carryOut} !== {1'b1, i[0], expCarry[i % 2]}) begin fails++; $display("FAIL alt_rsp[%0d] got %b exp %b", i, {rsp_valid, rsp_id, rsp_carryOut}, {1'b1, i[0], expCarry[i % 2]}); end
      tests++; if (rsp_result !== expRes[i % 2]) begin fails++; $display("FAIL alt_result[%0d] got %0d exp %0d", i, rsp_result, expRes[i % 2]); end
      @(negedge clk);
    end
  endtask

  task automatic test_stall;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if ({req0_ready, req1_ready} !== 2'b00) begin fails++; $display("FAIL stall_ready[%0d] got %b exp 00", i, {req0_ready, req1_ready}); end
      @(posedge clk); #1;
      tests++; if ({rsp_valid, rsp_id, rsp_result} !== {2'b11, 32'd18}) begin fails++; $display("FAIL stall_hold[%0d] got %b/%b/%0d exp 1/1/18", i, rsp_valid, rsp_id, rsp_result); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    tests++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL stall_release got %b exp 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    tests++; if ({rsp_valid, rsp_id, rsp_result} !== {2'b10, 32'd11}) begin fails++; $display("FAIL stall_next got %b/%b/%0d exp 1/0/11", rsp_valid, rsp_id, rsp_result); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    rsp_ready = 1'b0;
    reset = 1'b1;
    #1;
    tests++; if ({req0_ready, req1_ready} !== 2'b00) begin fails++; $display("FAIL midreset_ready got %b exp 00", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL midreset_valid got %b exp 0", rsp_valid); end
    @(negedge clk);
    reset = 1'b0; rsp_ready = 1'b1;
    #1;
    tests++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL midreset_prio got %b exp 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1;
    tests++; if ({rsp_valid, rsp_id, rsp_result} !== {2'b10, 32'd11}) begin fails++; $display("FAIL midreset_rsp got %b/%b/%0d exp 1/0/11", rsp_valid, rsp_id, rsp_result); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_wrap;
    test_back_to_back;
    test_stall;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
